counter_ctrl: RTL and testbench



---
 rtl/counter_ctrl_pkg.sv | 14 +
 rtl/counter_ctrl_prescaler.sv | 42 ++++
 rtl/counter_ctrl.sv | 175 +++++++++++++++++
 tb/tb_counter_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared types and default widths for the counter_ctrl interval timer.
package counter_ctrl_pkg;

  localparam int BW_DEFAULT = 8;
  localparam int PW_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/counter_ctrl_prescaler.sv
// Prescaler for counter_ctrl: counts 0..prescale_i and emits a one-cycle
// step when the count matches. clr_i has priority over en_i; en_i low holds.
module counter_ctrl_prescaler #(
  parameter int PW = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [PW-1:0] prescale_i,
  output logic          step_o
);

  localparam logic [PW-1:0] PS_ONE = {{(PW-1){1'b0}}, 1'b1};

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;
  logic          match;

  assign match  = (cnt_q == prescale_i);
  assign step_o = en_i && !clr_i && match;

  // Next prescaler value: clear, wrap on match, or increment when enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = match ? '0 : (cnt_q + PS_ONE);
    end
  end

  // Prescaler count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl: programmable interval timer controller (prescaler, down-count,
// one-shot or periodic). Optional macro COUNTER_CTRL_PAUSE_EN adds pause_i,
// which freezes the prescaler and count while in RUN.
//
// Config handshake: a transfer happens on a rising edge where
// cfg_valid_i && cfg_ready_o; cfg_ready_o is high only in IDLE and DONE, so
// offers made in ARMED or RUN are neither accepted nor consumed.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int BW = BW_DEFAULT,
  parameter int PW = PW_DEFAULT
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cfg_valid_i,
  output logic          cfg_ready_o,
  input  logic [BW-1:0] cfg_period_i,
  input  logic [PW-1:0] cfg_prescale_i,
  input  logic          cfg_periodic_i,
  input  logic          start_i,
  input  logic          stop_i,
`ifdef COUNTER_CTRL_PAUSE_EN
  input  logic          pause_i,
`endif
  output logic          busy_o,
  output logic          tick_o,
  output logic          done_o,
  output logic [BW-1:0] count_o,
  output logic [1:0]    dbg_state_o
);

  localparam logic [BW-1:0] CNT_ONE = {{(BW-1){1'b0}}, 1'b1};

  state_e        state_q, state_d;
  logic [BW-1:0] period_q, period_d;
  logic [PW-1:0] prescale_q, prescale_d;
  logic          periodic_q, periodic_d;
  logic [BW-1:0] count_q, count_d;
  logic          tick_q, tick_d;
  logic          done_q, done_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;

  logic          run_adv;
  logic          ps_clr;
  logic          step;
  logic          cfg_fire;

`ifdef COUNTER_CTRL_PAUSE_EN
  assign run_adv = !pause_i;
`else
  assign run_adv = 1'b1;
`endif

  assign cfg_fire = cfg_valid_i && ready_q;
  // The prescaler restarts from 0 on every entry to RUN and on abort.
  assign ps_clr   = (state_q != ST_RUN) || stop_i;

  counter_ctrl_prescaler #(.PW(PW)) u_prescaler (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (ps_clr),
    .en_i       ((state_q == ST_RUN) && run_adv),
    .prescale_i (prescale_q),
    .step_o     (step)
  );

  // Next-state, down-count and registered output values.
  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    prescale_d = prescale_q;
    periodic_d = periodic_q;
    count_d    = count_q;
    done_d     = done_q;
    tick_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cfg_fire) begin
          period_d   = cfg_period_i;
          prescale_d = cfg_prescale_i;
          periodic_d = cfg_periodic_i;
          count_d    = cfg_period_i;
          done_d     = 1'b0;
          state_d    = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (stop_i) begin
          count_d = '0;
          state_d = ST_IDLE;
        end else if (start_i) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Abort beats a coincident expiry: no tick, no done.
        if (stop_i) begin
          count_d = '0;
          state_d = ST_IDLE;
        end else if (step) begin
          if (count_q != '0) begin
            count_d = count_q - CNT_ONE;
          end else begin
            tick_d = 1'b1;
            if (periodic_q) begin
              count_d = period_q;
            end else begin
              done_d  = 1'b1;
              state_d = ST_DONE;
            end
          end
        end
      end
      ST_DONE: begin
        if (stop_i) begin
          done_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (cfg_fire) begin
          period_d   = cfg_period_i;
          prescale_d = cfg_prescale_i;
          periodic_d = cfg_periodic_i;
          count_d    = cfg_period_i;
          done_d     = 1'b0;
          state_d    = ST_ARMED;
        end else if (start_i) begin
          count_d = period_q;
          done_d  = 1'b0;
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
    busy_d  = (state_d == ST_RUN);
  end

  // State, configuration and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      period_q   <= '0;
      prescale_q <= '0;
      periodic_q <= 1'b0;
      count_q    <= '0;
      tick_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      period_q   <= period_d;
      prescale_q <= prescale_d;
      periodic_q <= periodic_d;
      count_q    <= count_d;
      tick_q     <= tick_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign cfg_ready_o = ready_q;
  assign busy_o      = busy_q;
  assign tick_o      = tick_q;
  assign done_o      = done_q;
  assign count_o     = count_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed testbench for counter_ctrl. Inputs change 1 ns after a rising
// edge; outputs are sampled at the same point, i.e. the values registered
// by the edge just passed.
module tb_counter_ctrl;
  import counter_ctrl_pkg::*;

  localparam int BW = 8;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [BW-1:0] cfg_period = '0;
  logic [PW-1:0] cfg_prescale = '0;
  logic          cfg_periodic = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
`ifdef COUNTER_CTRL_PAUSE_EN
  logic          pause = 1'b0;
`endif
  logic          busy;
  logic          tick;
  logic          done;
  logic [BW-1:0] count;
  logic [1:0]    dbg_state;

  int errors = 0;
  int checks = 0;

  // Clock and DUT.
  always #5 clk = ~clk;

  counter_ctrl #(.BW(BW), .PW(PW)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .cfg_valid_i    (cfg_valid),
    .cfg_ready_o    (cfg_ready),
    .cfg_period_i   (cfg_period),
    .cfg_prescale_i (cfg_prescale),
    .cfg_periodic_i (cfg_periodic),
    .start_i        (start),
    .stop_i         (stop),
`ifdef COUNTER_CTRL_PAUSE_EN
    .pause_i        (pause),
`endif
    .busy_o         (busy),
    .tick_o         (tick),
    .done_o         (done),
    .count_o        (count),
    .dbg_state_o    (dbg_state)
  );

  // Driver tasks.
  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input int p, input int ps, input bit per);
    cfg_valid    = 1'b1;
    cfg_period   = BW'(p);
    cfg_prescale = PW'(ps);
    cfg_periodic = per;
    step_clk();
    cfg_valid    = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step_clk();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step_clk();
    stop = 1'b0;
  endtask

  // Scenarios.
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", cfg_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", tick); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (count !== 8'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step_clk();
      checks++;
      if (tick !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
        errors++; $display("FAIL reset_release k=%0d tick=%b busy=%b ready=%b exp 0/0/1", k, tick, busy, cfg_ready);
      end
    end
  endtask

  task automatic test_oneshot();
    logic [BW-1:0] exp_cnt [4];
    exp_cnt = '{8'd2, 8'd1, 8'd0, 8'd0};
    do_cfg(3, 0, 1'b0);
    checks++; if (count !== 8'd3) begin errors++; $display("FAIL os_cfg_count got=%0d exp=3", count); end
    checks++; if (dbg_state !== ST_ARMED) begin errors++; $display("FAIL os_cfg_state got=%0d exp=%0d", dbg_state, ST_ARMED); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL os_cfg_ready got=%b exp=0", cfg_ready); end
    pulse_start();
    checks++; if (busy !== 1'b1 || count !== 8'd3) begin errors++; $display("FAIL os_start busy=%b count=%0d exp 1/3", busy, count); end
    for (int k = 0; k < 4; k++) begin
      step_clk();
      checks++; if (count !== exp_cnt[k]) begin errors++; $display("FAIL os_count k=%0d got=%0d exp=%0d", k, count, exp_cnt[k]); end
      checks++; if (tick !== (k == 3)) begin errors++; $display("FAIL os_tick k=%0d got=%b exp=%b", k, tick, (k == 3)); end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL os_done got=%b exp=1", done); end
    checks++; if (dbg_state !== ST_DONE) begin errors++; $display("FAIL os_state got=%0d exp=%0d", dbg_state, ST_DONE); end
    checks++; if (cfg_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL os_ready_busy got=%b/%b exp=1/0", cfg_ready, busy); end
    step_clk();
    checks++; if (tick !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL os_after tick=%b done=%b exp 0/1", tick, done); end
  endtask

  task automatic test_periodic();
    int  ticks;
    bit  busy_low;
    bit  done_high;
    logic [BW-1:0] exp_c;
    ticks = 0; busy_low = 1'b0; done_high = 1'b0;
    do_cfg(1, 2, 1'b1);
    checks++; if (done !== 1'b0 || count !== 8'd1) begin errors++; $display("FAIL per_cfg done=%b count=%0d exp 0/1", done, count); end
    pulse_start();
    for (int k = 1; k <= 30; k++) begin
      step_clk();
      if (tick === 1'b1) ticks++;
      if (busy !== 1'b1) busy_low = 1'b1;
      if (done !== 1'b0) done_high = 1'b1;
      exp_c = ((k % 6) >= 3) ? 8'd0 : 8'd1;
      checks++; if (tick !== ((k % 6) == 0)) begin errors++; $display("FAIL per_tick k=%0d got=%b exp=%b", k, tick, ((k % 6) == 0)); end
      checks++; if (count !== exp_c) begin errors++; $display("FAIL per_count k=%0d got=%0d exp=%0d", k, count, exp_c); end
    end
    checks++; if (ticks != 5) begin errors++; $display("FAIL per_ticks got=%0d exp=5", ticks); end
    checks++; if (busy_low || done_high) begin errors++; $display("FAIL per_flags busy_dropped=%b done_seen=%b exp 0/0", busy_low, done_high); end
    pulse_stop();
    checks++; if (dbg_state !== ST_IDLE || count !== 8'd0) begin errors++; $display("FAIL per_stop state=%0d count=%0d exp %0d/0", dbg_state, count, ST_IDLE); end
  endtask

  task automatic test_stop_vs_expiry();
    do_cfg(0, 0, 1'b1);
    pulse_start();
    step_clk();
    checks++; if (tick !== 1'b1) begin errors++; $display("FAIL sve_first_tick got=%b exp=1", tick); end
    stop = 1'b1;
    step_clk();
    stop = 1'b0;
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL sve_tick got=%b exp=0", tick); end
    checks++; if (dbg_state !== ST_IDLE || busy !== 1'b0) begin errors++; $display("FAIL sve_state state=%0d busy=%b exp %0d/0", dbg_state, busy, ST_IDLE); end
    checks++; if (count !== 8'd0 || done !== 1'b0) begin errors++; $display("FAIL sve_count count=%0d done=%b exp 0/0", count, done); end
  endtask

  task automatic test_handshake();
    do_cfg(2, 0, 1'b0);
    pulse_start();
    cfg_valid = 1'b1; cfg_period = 8'd7; cfg_periodic = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step_clk();
      checks++; if (count !== ((k == 0) ? 8'd1 : 8'd0)) begin errors++; $display("FAIL hs_run_count k=%0d got=%0d exp=%0d", k, count, ((k == 0) ? 1 : 0)); end
      checks++; if (cfg_ready !== 1'b0 || dbg_state !== ST_RUN) begin errors++; $display("FAIL hs_run_ready k=%0d ready=%b state=%0d exp 0/%0d", k, cfg_ready, dbg_state, ST_RUN); end
    end
    cfg_valid = 1'b0;
    step_clk();
    checks++; if (tick !== 1'b1 || done !== 1'b1 || dbg_state !== ST_DONE) begin errors++; $display("FAIL hs_expire tick=%b done=%b state=%0d exp 1/1/%0d", tick, done, dbg_state, ST_DONE); end
    cfg_valid = 1'b1; cfg_period = 8'd5; cfg_prescale = 4'd0; cfg_periodic = 1'b0;
    start = 1'b1;
    step_clk();
    cfg_valid = 1'b0; start = 1'b0;
    checks++; if (dbg_state !== ST_ARMED || busy !== 1'b0) begin errors++; $display("FAIL hs_cfg_wins state=%0d busy=%b exp %0d/0", dbg_state, busy, ST_ARMED); end
    checks++; if (count !== 8'd5 || done !== 1'b0) begin errors++; $display("FAIL hs_cfg_count count=%0d done=%b exp 5/0", count, done); end
  endtask

  task automatic test_retrigger_and_async_reset();
    pulse_start();
    for (int k = 1; k <= 6; k++) begin
      step_clk();
      checks++; if (tick !== (k == 6)) begin errors++; $display("FAIL rt_tick k=%0d got=%b exp=%b", k, tick, (k == 6)); end
    end
    checks++; if (dbg_state !== ST_DONE || done !== 1'b1) begin errors++; $display("FAIL rt_done state=%0d done=%b exp %0d/1", dbg_state, done, ST_DONE); end
    pulse_start();
    checks++; if (count !== 8'd5 || done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rt_retrigger count=%0d done=%b busy=%b exp 5/0/1", count, done, busy); end
    step_clk();
    checks++; if (count !== 8'd4) begin errors++; $display("FAIL rt_count got=%0d exp=4", count); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (count !== 8'd0 || busy !== 1'b0 || cfg_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL async_reset count=%0d busy=%b ready=%b state=%0d exp 0/0/1/%0d", count, busy, cfg_ready, dbg_state, ST_IDLE);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step_clk();
  endtask

`ifdef COUNTER_CTRL_PAUSE_EN
  task automatic test_pause();
    logic [BW-1:0] exp_cnt [3];
    exp_cnt = '{8'd1, 8'd0, 8'd0};
    do_cfg(4, 0, 1'b0);
    pulse_start();
    step_clk();
    step_clk();
    checks++; if (count !== 8'd2) begin errors++; $display("FAIL pause_pre count=%0d exp=2", count); end
    pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step_clk();
      checks++; if (count !== 8'd2 || tick !== 1'b0) begin errors++; $display("FAIL pause_hold k=%0d count=%0d tick=%b exp 2/0", k, count, tick); end
    end
    pause = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step_clk();
      checks++; if (count !== exp_cnt[k] || tick !== (k == 2)) begin errors++; $display("FAIL pause_resume k=%0d count=%0d tick=%b exp %0d/%b", k, count, tick, exp_cnt[k], (k == 2)); end
    end
  endtask
`endif

  // Test sequence and final report.
  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_stop_vs_expiry();
    test_handshake();
    test_retrigger_and_async_reset();
`ifdef COUNTER_CTRL_PAUSE_EN
    test_pause();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
